regfile_port_arbiter: RTL and testbench
=======================================

// Module: regfile_port_arbiter
// PURPOSE
//  Owns the LC-3 8x16 register file's write port (DR/inData/LDREG) and its SR2 read port.
//  Shares these ports between the core datapath and a debug/monitor requester.
//  After reset, zero-initialises R0..R7, because the register file has no reset of its own.
//  Sits between the control unit/writeback and the register file; the core's SR1 connects directly.
// PARAMETERS
//  DATA_W        16       register width
//  ADDR_W        3        register index width
//  NUM_REGS      8        registers initialised after reset (2**ADDR_W)
//  INIT_VALUE    16'h0000 value written to every register during INIT
//  STARVE_LIMIT  4        lost arbitration cycles before a pending debug op is forced through
// PORTS
//  clk          in   1       clock, all state updates on posedge
//  reset        in   1       synchronous, active-high reset
//  core_wr_valid in  1       core writeback request
//  core_wr_ready out 1       core write accepted this cycle
//  core_dr      in   ADDR_W  core destination register
//  core_wdata   in   DATA_W  core write data
//  core_sr2     in   ADDR_W  core SR2 index
//  core_sr2_use in   1       core needs SR2OUT this cycle
//  core_rd_stall out 1       SR2 port taken by debug; core must hold the current instruction
//  dbg_valid    in   1       debug request
//  dbg_ready    out  1       debug request accepted this cycle
//  dbg_we       in   1       1=write, 0=read
//  dbg_addr     in   ADDR_W  debug register index
//  dbg_wdata    in   DATA_W  debug write data
//  dbg_rvalid   out  1       dbg_rdata valid (1-cycle pulse)
//  dbg_rdata    out  DATA_W  debug read data
//  rf_dr        out  ADDR_W  to regfile DR
//  rf_indata    out  DATA_W  to regfile inData
//  rf_ldreg     out  1       to regfile LDREG
//  rf_sr2       out  ADDR_W  to regfile SR2
//  rf_sr2out    in   DATA_W  from regfile SR2OUT
//  init_done    out  1       high once INIT has completed
// BEHAVIOUR
//  Reset: state=INIT, init_ptr=0, starve_cnt=0, init_done=0, dbg_rvalid=0, dbg_rdata=0.
//   While reset=1: rf_ldreg=0, all ready outputs=0, core_rd_stall=0.
//  FSM INIT: rf_ldreg=1, rf_dr=init_ptr, rf_indata=INIT_VALUE; init_ptr++ each cycle.
//   INIT lasts exactly NUM_REGS cycles. After the write of R7: state=RUN, init_done=1.
//   In INIT, core_wr_ready=0 and dbg_ready=0.
//  FSM RUN: stays in RUN until reset. A transfer occurs when valid & ready are high at the same posedge.
//   Requesters hold valid and payload stable until ready.
//  Write port: 1 write per cycle. Core has priority when starve_cnt<STARVE_LIMIT.
//   When starve_cnt==STARVE_LIMIT, a pending debug write wins and core_wr_ready=0.
//  Debug read: granted if core_sr2_use==0 or starve_cnt==STARVE_LIMIT.
//   If granted while core_sr2_use==1: core_rd_stall=1.
//   On grant: rf_sr2=dbg_addr; otherwise rf_sr2=core_sr2.
//   dbg_rdata<=rf_sr2out at the grant edge; dbg_rvalid=1 the following cycle for exactly 1 cycle.
//   Back-to-back reads run at 1 per cycle.
//  Debug reads never contend with core writes; a debug read and a core write may both be granted in one cycle.
//  starve_cnt: +1 per cycle with dbg_valid&!dbg_ready, saturates at STARVE_LIMIT, cleared on a debug transfer.
//  Read of a register written in the same cycle returns the pre-write value (no bypass).
//  Same-register collision (core and debug writes to one index): the loser retries later, so the later-granted write persists.
//  All ready/stall outputs are combinational from state, starve_cnt and the request inputs. No ready depends on its own valid.
//  Reset mid-INIT or mid-RUN: restart INIT at R0. A pending dbg_rvalid is dropped; the requester reissues.
// STRUCTURE
//  Package lc3_regarb_pkg: state enum {INIT,RUN}, DATA_W/ADDR_W constants, INIT_VALUE.
//  One sub-module, regarb_starve_counter (saturating counter with clear), used once.
//  Everything else is flat: FSM, init_ptr and the grant/mux logic.
// TESTING
//  1 Release reset -> rf_ldreg=1 for 8 cycles, rf_dr 0..7, data 0x0000; init_done=1 on cycle 8; dbg read R5 -> 0x0000.
//  2 Core write R3=0x1234 and dbg write R3=0xBEEF, same cycle -> core granted cycle 0, dbg cycle 1; read R3 -> 0xBEEF.
//  3 core_wr_valid held high, dbg write R1=0x0055 pending -> dbg_ready on 5th cycle (after 4 losses), core_wr_ready=0 that cycle.
//  4 Dbg read R2 (=0x0A0A) with core_sr2_use=1 held -> cycle 5: core_rd_stall=1, rf_sr2=2; next cycle dbg_rvalid=1, rdata 0x0A0A.
//  5 Dbg read R6 in the same cycle core writes R6=0x00FF -> rdata = old 0x0000; re-read -> 0x00FF.
//  6 Reset during INIT after 3 writes, and during RUN with rvalid due -> dbg_rvalid=0; INIT restarts at R0, takes 8 full cycles.

Source files
------------

// File: rtl/lc3_regarb_pkg.sv
// Shared types and constants for the LC-3 register-file port arbiter.
//   regarb_state_e : arbiter FSM state (INIT clears R0..R7, RUN arbitrates)
//   DATA_W/ADDR_W  : register width and register index width
//   INIT_VALUE     : value written to every register after reset
package lc3_regarb_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned ADDR_W = 3;
    localparam logic [DATA_W-1:0] INIT_VALUE = 16'h0000;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } regarb_state_e;

endpackage

// File: rtl/regarb_starve_counter.sv
// Saturating counter of cycles a debug request has lost arbitration.
//   clk, reset : clock, synchronous active-high reset
//   inc        : debug request pending but not accepted this cycle
//   clr        : debug transfer this cycle (dominates inc)
//   sat        : counter has reached LIMIT; debug request must be forced through
module regarb_starve_counter #(
    parameter int unsigned LIMIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic clr,
    output logic sat
);

    localparam int unsigned CNT_W = $clog2(LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LIMIT);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign sat = (cnt_q == CNT_MAX);

endmodule

// File: rtl/regfile_port_arbiter.sv
// Shares the LC-3 register file's write port and SR2 read port between the
// core datapath and a debug requester, and zero-initialises R0..R7 after reset.
//   clk, reset                      : clock, synchronous active-high reset
//   core_wr_valid/ready, core_dr,
//   core_wdata                      : core writeback request
//   core_sr2, core_sr2_use          : core SR2 read index / SR2 needed this cycle
//   core_rd_stall                   : SR2 port taken by debug, core must hold
//   dbg_valid/ready, dbg_we,
//   dbg_addr, dbg_wdata             : debug read/write request
//   dbg_rvalid, dbg_rdata           : debug read response (one cycle after grant)
//   rf_dr, rf_indata, rf_ldreg      : register file write port
//   rf_sr2, rf_sr2out               : register file SR2 read port
//   init_done                       : register initialisation has completed
module regfile_port_arbiter #(
    parameter int unsigned DATA_W       = lc3_regarb_pkg::DATA_W,
    parameter int unsigned ADDR_W       = lc3_regarb_pkg::ADDR_W,
    parameter int unsigned NUM_REGS     = 2 ** ADDR_W,
    parameter logic [DATA_W-1:0] INIT_VALUE = lc3_regarb_pkg::INIT_VALUE,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              core_wr_valid,
    output logic              core_wr_ready,
    input  logic [ADDR_W-1:0] core_dr,
    input  logic [DATA_W-1:0] core_wdata,
    input  logic [ADDR_W-1:0] core_sr2,
    input  logic              core_sr2_use,
    output logic              core_rd_stall,
    input  logic              dbg_valid,
    output logic              dbg_ready,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_rvalid,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic [ADDR_W-1:0] rf_dr,
    output logic [DATA_W-1:0] rf_indata,
    output logic              rf_ldreg,
    output logic [ADDR_W-1:0] rf_sr2,
    input  logic [DATA_W-1:0] rf_sr2out,
    output logic              init_done
);

    import lc3_regarb_pkg::*;

    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(NUM_REGS - 1);

    regarb_state_e     state_q, state_d;
    logic [ADDR_W-1:0] init_ptr_q, init_ptr_d;
    logic              init_done_q, init_done_d;
    logic              dbg_rvalid_q, dbg_rvalid_d;
    logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;

    logic run;
    logic starved;
    logic starve_inc, starve_clr;
    logic dbg_wr_fire, dbg_rd_grant, core_wr_fire;

    regarb_starve_counter #(
        .LIMIT (STARVE_LIMIT)
    ) u_starve (
        .clk   (clk),
        .reset (reset),
        .inc   (starve_inc),
        .clr   (starve_clr),
        .sat   (starved)
    );

    always_comb begin
        // Outputs are gated with reset directly because state_q only
        // returns to INIT at the edge that samples reset.
        run = !reset && (state_q == ST_RUN);

        // Debug reads use SR2 and debug writes use the write port, so each
        // kind only contends with the matching core request.
        core_wr_ready = run && !(starved && dbg_valid && dbg_we);
        dbg_ready     = run && (starved || (dbg_we ? !core_wr_valid : !core_sr2_use));

        core_wr_fire  = core_wr_valid && core_wr_ready;
        dbg_wr_fire   = dbg_valid && dbg_we && dbg_ready;
        dbg_rd_grant  = dbg_valid && !dbg_we && dbg_ready;
        core_rd_stall = dbg_rd_grant && core_sr2_use;

        starve_inc = dbg_valid && !dbg_ready;
        starve_clr = dbg_valid && dbg_ready;

        rf_sr2    = dbg_rd_grant ? dbg_addr : core_sr2;
        rf_ldreg  = 1'b0;
        rf_dr     = core_dr;
        rf_indata = core_wdata;
        if (!reset && (state_q == ST_INIT)) begin
            rf_ldreg  = 1'b1;
            rf_dr     = init_ptr_q;
            rf_indata = INIT_VALUE;
        end else if (core_wr_fire) begin
            rf_ldreg  = 1'b1;
        end else if (dbg_wr_fire) begin
            rf_ldreg  = 1'b1;
            rf_dr     = dbg_addr;
            rf_indata = dbg_wdata;
        end

        state_d     = state_q;
        init_ptr_d  = init_ptr_q;
        init_done_d = init_done_q;
        if (state_q == ST_INIT) begin
            init_ptr_d = init_ptr_q + 1'b1;
            if (init_ptr_q == LAST_PTR) begin
                state_d     = ST_RUN;
                init_done_d = 1'b1;
            end
        end

        // Register file is read before its write lands: no bypass.
        dbg_rvalid_d = dbg_rd_grant;
        dbg_rdata_d  = dbg_rd_grant ? rf_sr2out : dbg_rdata_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_INIT;
            init_ptr_q   <= '0;
            init_done_q  <= 1'b0;
            dbg_rvalid_q <= 1'b0;
            dbg_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            init_ptr_q   <= init_ptr_d;
            init_done_q  <= init_done_d;
            dbg_rvalid_q <= dbg_rvalid_d;
            dbg_rdata_q  <= dbg_rdata_d;
        end
    end

    assign init_done  = init_done_q;
    assign dbg_rvalid = dbg_rvalid_q;
    assign dbg_rdata  = dbg_rdata_q;

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// Directed bench for regfile_port_arbiter with a behavioural 8x16 register file.
module tb_regfile_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        core_wr_valid, core_wr_ready;
    logic [2:0]  core_dr, core_sr2;
    logic [15:0] core_wdata;
    logic        core_sr2_use, core_rd_stall;
    logic        dbg_valid, dbg_ready, dbg_we;
    logic [2:0]  dbg_addr;
    logic [15:0] dbg_wdata;
    logic        dbg_rvalid;
    logic [15:0] dbg_rdata;
    logic [2:0]  rf_dr, rf_sr2;
    logic [15:0] rf_indata, rf_sr2out;
    logic        rf_ldreg, init_done;

    int errors = 0;
    int checks = 0;

    logic [15:0] rf_mem [8] = '{default: 16'hDEAD};

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rf_ldreg) rf_mem[rf_dr] <= rf_indata;
    end
    assign rf_sr2out = rf_mem[rf_sr2];

    regfile_port_arbiter #(
        .DATA_W       (16),
        .ADDR_W       (3),
        .NUM_REGS     (8),
        .INIT_VALUE   (16'h0000),
        .STARVE_LIMIT (4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .core_wr_valid (core_wr_valid),
        .core_wr_ready (core_wr_ready),
        .core_dr       (core_dr),
        .core_wdata    (core_wdata),
        .core_sr2      (core_sr2),
        .core_sr2_use  (core_sr2_use),
        .core_rd_stall (core_rd_stall),
        .dbg_valid     (dbg_valid),
        .dbg_ready     (dbg_ready),
        .dbg_we        (dbg_we),
        .dbg_addr      (dbg_addr),
        .dbg_wdata     (dbg_wdata),
        .dbg_rvalid    (dbg_rvalid),
        .dbg_rdata     (dbg_rdata),
        .rf_dr         (rf_dr),
        .rf_indata     (rf_indata),
        .rf_ldreg      (rf_ldreg),
        .rf_sr2        (rf_sr2),
        .rf_sr2out     (rf_sr2out),
        .init_done     (init_done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic dbg_read(input logic [2:0] addr, input logic [15:0] exp, input string tag);
        int n = 0;
        dbg_valid = 1'b1; dbg_we = 1'b0; dbg_addr = addr;
        #1;
        while (!dbg_ready && n < 20) begin tick(); n++; end
        chk({tag, "_grant"}, dbg_ready, 1);
        tick();
        dbg_valid = 1'b0;
        #1;
        chk({tag, "_rvalid"}, dbg_rvalid, 1);
        chk({tag, "_rdata"}, dbg_rdata, exp);
        tick();
        chk({tag, "_rvalid_pulse"}, dbg_rvalid, 0);
    endtask

    task automatic dbg_write(input logic [2:0] addr, input logic [15:0] data, input string tag);
        int n = 0;
        dbg_valid = 1'b1; dbg_we = 1'b1; dbg_addr = addr; dbg_wdata = data;
        #1;
        while (!dbg_ready && n < 20) begin tick(); n++; end
        chk({tag, "_grant"}, dbg_ready, 1);
        tick();
        dbg_valid = 1'b0; dbg_we = 1'b0;
        #1;
    endtask

    initial begin
        reset = 1'b1;
        core_wr_valid = 1'b0; core_dr = '0; core_wdata = '0;
        core_sr2 = '0; core_sr2_use = 1'b0;
        dbg_valid = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
        tick(); tick();

        // Reset state, with requests present.
        core_wr_valid = 1'b1; dbg_valid = 1'b1; core_sr2_use = 1'b1;
        #1;
        chk("rst_ldreg", rf_ldreg, 0);
        chk("rst_core_ready", core_wr_ready, 0);
        chk("rst_dbg_ready", dbg_ready, 0);
        chk("rst_stall", core_rd_stall, 0);
        chk("rst_init_done", init_done, 0);
        chk("rst_rvalid", dbg_rvalid, 0);
        chk("rst_rdata", dbg_rdata, 0);
        core_wr_valid = 1'b0; dbg_valid = 1'b0; core_sr2_use = 1'b0;

        // 1: INIT sequence and first read.
        reset = 1'b0;
        #1;
        for (int i = 0; i < 8; i++) begin
            chk("init_ldreg", rf_ldreg, 1);
            chk("init_dr", rf_dr, i);
            chk("init_data", rf_indata, 0);
            chk("init_done_low", init_done, 0);
            chk("init_dbg_ready", dbg_ready, 0);
            tick();
        end
        chk("init_done_high", init_done, 1);
        chk("run_ldreg_idle", rf_ldreg, 0);
        dbg_read(3'd5, 16'h0000, "t1_r5");

        // 2: same-register write collision, core first then debug.
        core_wr_valid = 1'b1; core_dr = 3'd3; core_wdata = 16'h1234;
        dbg_valid = 1'b1; dbg_we = 1'b1; dbg_addr = 3'd3; dbg_wdata = 16'hBEEF;
        #1;
        chk("t2_core_ready", core_wr_ready, 1);
        chk("t2_dbg_wait", dbg_ready, 0);
        chk("t2_wdata_core", rf_indata, 16'h1234);
        tick();
        core_wr_valid = 1'b0;
        #1;
        chk("t2_dbg_ready", dbg_ready, 1);
        chk("t2_wdata_dbg", rf_indata, 16'hBEEF);
        chk("t2_dr_dbg", rf_dr, 3);
        tick();
        dbg_valid = 1'b0; dbg_we = 1'b0;
        dbg_read(3'd3, 16'hBEEF, "t2_r3");

        // 3: write starvation forces debug through on the 5th cycle.
        core_wr_valid = 1'b1; core_dr = 3'd0; core_wdata = 16'h1111;
        dbg_valid = 1'b1; dbg_we = 1'b1; dbg_addr = 3'd1; dbg_wdata = 16'h0055;
        #1;
        for (int i = 0; i < 4; i++) begin
            chk("t3_dbg_lose", dbg_ready, 0);
            chk("t3_core_win", core_wr_ready, 1);
            tick();
        end
        chk("t3_dbg_forced", dbg_ready, 1);
        chk("t3_core_blocked", core_wr_ready, 0);
        chk("t3_forced_dr", rf_dr, 1);
        chk("t3_forced_data", rf_indata, 16'h0055);
        tick();
        dbg_valid = 1'b0; dbg_we = 1'b0;
        #1;
        chk("t3_core_after", core_wr_ready, 1);
        tick();
        core_wr_valid = 1'b0;
        dbg_read(3'd1, 16'h0055, "t3_r1");
        dbg_read(3'd0, 16'h1111, "t3_r0");

        // 4: read starvation steals SR2 from the core on the 5th cycle.
        dbg_write(3'd2, 16'h0A0A, "t4_w2");
        core_sr2_use = 1'b1; core_sr2 = 3'd7;
        dbg_valid = 1'b1; dbg_we = 1'b0; dbg_addr = 3'd2;
        #1;
        for (int i = 0; i < 4; i++) begin
            chk("t4_dbg_lose", dbg_ready, 0);
            chk("t4_no_stall", core_rd_stall, 0);
            chk("t4_sr2_core", rf_sr2, 7);
            tick();
        end
        chk("t4_stall", core_rd_stall, 1);
        chk("t4_sr2_dbg", rf_sr2, 2);
        chk("t4_dbg_ready", dbg_ready, 1);
        tick();
        dbg_valid = 1'b0;
        #1;
        chk("t4_rvalid", dbg_rvalid, 1);
        chk("t4_rdata", dbg_rdata, 16'h0A0A);
        chk("t4_stall_off", core_rd_stall, 0);
        tick();
        chk("t4_rvalid_pulse", dbg_rvalid, 0);
        core_sr2_use = 1'b0;

        // 5: read and write of R6 in the same cycle, no bypass.
        core_wr_valid = 1'b1; core_dr = 3'd6; core_wdata = 16'h00FF;
        dbg_valid = 1'b1; dbg_we = 1'b0; dbg_addr = 3'd6;
        #1;
        chk("t5_core_ready", core_wr_ready, 1);
        chk("t5_dbg_ready", dbg_ready, 1);
        tick();
        core_wr_valid = 1'b0; dbg_valid = 1'b0;
        #1;
        chk("t5_rvalid", dbg_rvalid, 1);
        chk("t5_old_data", dbg_rdata, 16'h0000);
        tick();
        dbg_read(3'd6, 16'h00FF, "t5_reread");

        // 6: reset mid-INIT restarts at R0.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("t6_init_a_dr", rf_dr, i);
            tick();
        end
        reset = 1'b1;
        #1;
        chk("t6_rst_ldreg", rf_ldreg, 0);
        tick();
        reset = 1'b0;
        #1;
        for (int i = 0; i < 8; i++) begin
            chk("t6_init_b_ldreg", rf_ldreg, 1);
            chk("t6_init_b_dr", rf_dr, i);
            chk("t6_init_b_done", init_done, 0);
            tick();
        end
        chk("t6_init_b_done_high", init_done, 1);

        // 6b: reset in RUN at the edge a read would be granted drops the response.
        dbg_valid = 1'b1; dbg_we = 1'b0; dbg_addr = 3'd4;
        #1;
        chk("t6_pre_ready", dbg_ready, 1);
        reset = 1'b1;
        #1;
        chk("t6_rst_ready", dbg_ready, 0);
        tick();
        chk("t6_rvalid_dropped", dbg_rvalid, 0);
        dbg_valid = 1'b0;
        reset = 1'b0;
        #1;
        for (int i = 0; i < 8; i++) begin
            chk("t6_init_c_dr", rf_dr, i);
            tick();
        end
        chk("t6_init_c_done", init_done, 1);
        dbg_read(3'd3, 16'h0000, "t6_r3_cleared");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
